// File: rtl/lt24_frame_scheduler.sv
// Raster-scan pixel sequencer for the LT24 big-screen: picture window from Subject ROM, background elsewhere.
// Optional result overlay box compiled in with `define BIGSCREEN_RESULT_OVERLAY_EN.
module lt24_frame_scheduler #(
  parameter int          LCD_WIDTH   = 240,
  parameter int          LCD_HEIGHT  = 320,
  parameter int          PIC_X_START = 60,
  parameter int          PIC_Y_START = 0,
  parameter int          PIC_WIDTH   = 120,
  parameter int          PIC_HEIGHT  = 320,
  parameter int          ROM_LATENCY = 1,
  parameter logic [15:0] BACK_COLOR  = 16'h0000,
  parameter bit          CONTINUOUS  = 1'b1
) (
  input  logic        clock,
  input  logic        globalReset,
  input  logic        resetApp,
  input  logic        frameStart,
  input  logic        ansCorrect,
  input  logic        ansWrong,
  input  logic        pixelReady,
  input  logic [15:0] romData,
  output logic [15:0] romAddr,
  output logic [7:0]  xAddr,
  output logic [8:0]  yAddr,
  output logic [15:0] pixelData,
  output logic        pixelWrite,
  output logic        frameBusy,
  output logic        frameDone
);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

  state_t      state;
  logic [1:0]  lat_cnt;
  logic        start_req;
  logic        last_col;
  logic        last_pixel;
  logic [7:0]  next_x;
  logic [8:0]  next_y;
  logic [15:0] pixel_sel;

  function automatic logic in_window(input logic [7:0] x, input logic [8:0] y);
    return int'(x) >= PIC_X_START && int'(x) < PIC_X_START + PIC_WIDTH &&
           int'(y) >= PIC_Y_START && int'(y) < PIC_Y_START + PIC_HEIGHT;
  endfunction

  // Modulo-2^16 arithmetic gives the truncated address directly.
  function automatic logic [15:0] rom_addr_of(input logic [7:0] x, input logic [8:0] y);
    if (!in_window(x, y)) return 16'h0000;
    return (16'(x) - 16'(PIC_X_START)) + (16'(y) - 16'(PIC_Y_START)) * 16'(PIC_WIDTH);
  endfunction

  assign start_req = CONTINUOUS || frameStart;

`ifdef BIGSCREEN_RESULT_OVERLAY_EN
  logic ans_correct_q;
  logic ans_wrong_q;
  logic in_box;

  // Wrong is masked by correct at latch time so correct always wins.
  always_ff @(posedge clock or posedge globalReset) begin
    if (globalReset) begin
      ans_correct_q <= 1'b0;
      ans_wrong_q   <= 1'b0;
    end else if (resetApp) begin
      ans_correct_q <= 1'b0;
      ans_wrong_q   <= 1'b0;
    end else if (state == IDLE && start_req) begin
      ans_correct_q <= ansCorrect;
      ans_wrong_q   <= ansWrong & ~ansCorrect;
    end
  end

  assign in_box = xAddr >= 8'd4 && xAddr <= 8'd35 && yAddr >= 9'd4 && yAddr <= 9'd35;
`else
  logic unused_ans;
  assign unused_ans = ansCorrect ^ ansWrong;
`endif

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    last_col   = int'(xAddr) == LCD_WIDTH - 1;
    last_pixel = last_col && int'(yAddr) == LCD_HEIGHT - 1;
    next_x     = last_col ? 8'd0 : xAddr + 8'd1;
    next_y     = last_col ? yAddr + 9'd1 : yAddr;
    pixel_sel  = BACK_COLOR;
    if (in_window(xAddr, yAddr)) pixel_sel = romData;
`ifdef BIGSCREEN_RESULT_OVERLAY_EN
    if (in_box && (ans_correct_q || ans_wrong_q))
      pixel_sel = ans_correct_q ? 16'h07E0 : 16'hF800;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge globalReset) begin
    if (globalReset) begin
      state      <= IDLE;
      lat_cnt    <= 2'd0;
      xAddr      <= 8'd0;
      yAddr      <= 9'd0;
      romAddr    <= 16'h0000;
      pixelData  <= BACK_COLOR;
      pixelWrite <= 1'b0;
      frameBusy  <= 1'b0;
      frameDone  <= 1'b0;
    end else if (resetApp) begin
      state      <= IDLE;
      lat_cnt    <= 2'd0;
      xAddr      <= 8'd0;
      yAddr      <= 9'd0;
      romAddr    <= 16'h0000;
      pixelData  <= BACK_COLOR;
      pixelWrite <= 1'b0;
      frameBusy  <= 1'b0;
      frameDone  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_req) begin
            state     <= FETCH;
            xAddr     <= 8'd0;
            yAddr     <= 9'd0;
            romAddr   <= rom_addr_of(8'd0, 9'd0);
            lat_cnt   <= 2'd0;
            frameBusy <= 1'b1;
          end
        end
        FETCH: begin
          // Same wait in and out of the window keeps pixel cadence uniform.
          if (int'(lat_cnt) == ROM_LATENCY) begin
            pixelData  <= pixel_sel;
            pixelWrite <= 1'b1;
            state      <= PRESENT;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        PRESENT: begin
          if (pixelReady) begin
            pixelWrite <= 1'b0;
            if (last_pixel) begin
              state     <= DONE;
              frameDone <= 1'b1;
              frameBusy <= 1'b0;
            end else begin
              xAddr   <= next_x;
              yAddr   <= next_y;
              romAddr <= rom_addr_of(next_x, next_y);
              lat_cnt <= 2'd0;
              state   <= FETCH;
            end
          end
        end
        DONE: begin
          frameDone <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
